// File: rtl/video_timing_fb_reader.sv
// rtl/video_timing_fb_reader.sv - raster timing generator and latency-compensated greyscale frame-buffer reader
// Optional colour-bar source enabled by defining VTFB_TEST_PATTERN_EN.
module video_timing_fb_reader #(
  parameter int          H_VISIBLE = 1920,
  parameter int          H_FP      = 88,
  parameter int          H_SYNC    = 44,
  parameter int          H_BP      = 148,
  parameter int          V_VISIBLE = 1080,
  parameter int          V_FP      = 4,
  parameter int          V_SYNC    = 5,
  parameter int          V_BP      = 36,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int          IMG_W     = 500,
  parameter int          IMG_H     = 500,
  parameter int          ADDR_W    = 18,
  parameter int          RD_LAT    = 1,
  parameter logic [23:0] BG_COLOUR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [11:0]       img_x0,
  input  logic [11:0]       img_y0,
`ifdef VTFB_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] addra,
  input  logic [7:0]        douta,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam logic [11:0] HMAX = 12'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VMAX = 12'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HV   = 12'(H_VISIBLE);
  localparam logic [11:0] VV   = 12'(V_VISIBLE);
  localparam logic [11:0] HSS  = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HSE  = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VSS  = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VSE  = 12'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [12:0] HV13 = 13'(H_VISIBLE);
  localparam logic [12:0] IW13 = 13'(IMG_W);
  localparam logic [12:0] IH13 = 13'(IMG_H);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [11:0] hc, vc, x0_s, y0_s;
  logic        run, line_end, frame_end, capture;
  logic        de0, hs0, vs0, win0, fs0, in_x, in_y, row_adv;
  logic [12:0] hc13, vc13, x_lo, y_lo;
  logic [ADDR_W-1:0] row_base;
  logic [RD_LAT:0] de_p, hs_p, vs_p, win_p, fs_p;

  assign run       = (state_q == RUN);
  assign line_end  = (hc == HMAX);
  assign frame_end = run && line_end && (vc == VMAX);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = RUN;
        capture = 1'b1;
      end
      RUN: if (frame_end) begin
        capture = 1'b1;
        if (!enable) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!run) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= (vc == VMAX) ? 12'd0 : vc + 12'd1;
    end else begin
      hc <= hc + 12'd1;
    end
  end

`ifdef VTFB_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_VISIBLE / 8);
  logic             tm_s;
  logic [2:0]       bar0;
  logic [RD_LAT:0]  tp_p;
  logic [2:0]       bar_p [RD_LAT+1];

  assign bar0 = 3'(hc / BAR_W);

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_s <= '0;
      y0_s <= '0;
`ifdef VTFB_TEST_PATTERN_EN
      tm_s <= 1'b0;
`endif
    end else if (capture) begin
      x0_s <= img_x0;
      y0_s <= img_y0;
`ifdef VTFB_TEST_PATTERN_EN
      tm_s <= test_mode;
`endif
    end
  end

  // Window bounds are 13 bits wide so x0+IMG_W never wraps back into range.
  assign hc13 = {1'b0, hc};
  assign vc13 = {1'b0, vc};
  assign x_lo = {1'b0, x0_s};
  assign y_lo = {1'b0, y0_s};
  assign in_x = (hc13 >= x_lo) && (hc13 < x_lo + IW13);
  assign in_y = (vc13 >= y_lo) && (vc13 < y_lo + IH13);
  assign de0  = run && (hc < HV) && (vc < VV);
  assign hs0  = run && (hc >= HSS) && (hc < HSE);
  assign vs0  = run && (vc >= VSS) && (vc < VSE);
  assign fs0  = run && (hc == 12'd0) && (vc == 12'd0);
`ifdef VTFB_TEST_PATTERN_EN
  assign win0 = de0 && in_x && in_y && !tm_s;
`else
  assign win0 = de0 && in_x && in_y;
`endif
  // Rows advance by the full image width even when clipped, so cropping never skews.
  assign row_adv = run && line_end && in_y && (vc < VV) && (x_lo < HV13);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      addra    <= '0;
    end else begin
      if (!run || frame_end) row_base <= '0;
      else if (row_adv)      row_base <= row_base + ADDR_W'(IMG_W);
      if (win0) addra <= row_base + ADDR_W'(hc - x0_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p  <= '0;
      hs_p  <= '0;
      vs_p  <= '0;
      win_p <= '0;
      fs_p  <= '0;
`ifdef VTFB_TEST_PATTERN_EN
      tp_p  <= '0;
      for (int i = 0; i <= RD_LAT; i++) bar_p[i] <= '0;
`endif
    end else begin
      de_p  <= {de_p[RD_LAT-1:0], de0};
      hs_p  <= {hs_p[RD_LAT-1:0], hs0};
      vs_p  <= {vs_p[RD_LAT-1:0], vs0};
      win_p <= {win_p[RD_LAT-1:0], win0};
      fs_p  <= {fs_p[RD_LAT-1:0], fs0};
`ifdef VTFB_TEST_PATTERN_EN
      tp_p     <= {tp_p[RD_LAT-1:0], tm_s};
      bar_p[0] <= bar0;
      for (int i = 1; i <= RD_LAT; i++) bar_p[i] <= bar_p[i-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r, g, b}   <= 24'h000000;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      de          <= de_p[RD_LAT];
      hsync       <= hs_p[RD_LAT] ? HS_POL : ~HS_POL;
      vsync       <= vs_p[RD_LAT] ? VS_POL : ~VS_POL;
      frame_start <= fs_p[RD_LAT];
      if (!de_p[RD_LAT])      {r, g, b} <= 24'h000000;
`ifdef VTFB_TEST_PATTERN_EN
      else if (tp_p[RD_LAT])  {r, g, b} <= bar_colour(bar_p[RD_LAT]);
`endif
      else if (win_p[RD_LAT]) {r, g, b} <= {douta, douta, douta};
      else                    {r, g, b} <= BG_COLOUR;
    end
  end

endmodule

// File: tb/tb_video_timing_fb_reader.sv
// tb/tb_video_timing_fb_reader.sv - scoreboard bench for video_timing_fb_reader in a 14x9 test mode
module tb_video_timing_fb_reader;

  localparam logic [23:0] BG = 24'h203040;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [11:0] img_x0, img_y0;
  logic [7:0] addra, douta, p1, r, g, b;
  logic       de, hsync, vsync, frame_start;

  int checks = 0;
  int errors = 0;
  logic [23:0] q[$];

  always #5 clk = ~clk;

  video_timing_fb_reader #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .IMG_W(4), .IMG_H(3),
    .ADDR_W(8), .RD_LAT(2), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .img_x0(img_x0), .img_y0(img_y0),
    .addra(addra), .douta(douta), .r(r), .g(g), .b(b), .de(de),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  // BRAM model with two clocks of read latency, contents mem[a] = a
  initial begin
    p1 = 8'd0;
    douta = 8'd0;
  end
  always @(posedge clk) begin
    p1    <= addra;
    douta <= p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int x0, input int y0);
    logic [7:0] v;
    for (int vc = 0; vc < 6; vc++)
      for (int hc = 0; hc < 8; hc++)
        if (hc >= x0 && hc < x0 + 4 && vc >= y0 && vc < y0 + 3) begin
          v = 8'((vc - y0) * 4 + (hc - x0));
          q.push_back({v, v, v});
        end else begin
          q.push_back(BG);
        end
  endtask

  task automatic wait_fs(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_start && n < max);
  endtask

  always @(negedge clk) begin
    if (rst_n && de) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_underflow: got %0h expected none", {r, g, b});
      end else begin
        chk("pixel", {r, g, b}, q.pop_front());
      end
    end
  end

  initial begin
    int n, hs_low, vs_hi, vs_first, de_cnt, idle_de, idle_fs, idle_hs, idle_vs;
    rst_n = 1'b0;
    enable = 1'b0;
    img_x0 = 12'd2;
    img_y0 = 12'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addra", addra, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 0);

    push_frame(2, 1);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    wait_fs(50, n);
    chk("first_fs_latency", n, 5);
    chk("fs_with_de", de, 1);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("hsync_pos", hsync, (k == 10 || k == 11) ? 0 : 1);
    end

    img_x0 = 12'd6;
    push_frame(6, 1);
    wait_fs(200, n);
    chk("frame_period", n + 13, 126);

    hs_low = 0; vs_hi = 0; vs_first = -1; de_cnt = 0;
    for (int k = 0; k < 126; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 20) enable = 1'b0;
      if (!hsync) hs_low++;
      if (vsync) begin
        vs_hi++;
        if (vs_first < 0) vs_first = k;
      end
      if (de) de_cnt++;
    end
    chk("hsync_low_count", hs_low, 18);
    chk("vsync_high_count", vs_hi, 14);
    chk("vsync_first", vs_first, 98);
    chk("de_count", de_cnt, 48);

    idle_de = 0; idle_fs = 0; idle_hs = 0; idle_vs = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (de) idle_de++;
      if (frame_start) idle_fs++;
      if (!hsync) idle_hs++;
      if (vsync) idle_vs++;
    end
    chk("idle_de", idle_de, 0);
    chk("idle_fs", idle_fs, 0);
    chk("idle_hsync", idle_hs, 0);
    chk("idle_vsync", idle_vs, 0);
    chk("queue_drained", q.size(), 0);

    img_x0 = 12'd2;
    img_y0 = 12'd4;
    push_frame(2, 4);
    @(negedge clk);
    enable = 1'b1;
    wait_fs(50, n);
    chk("reenable_fs_latency", n, 5);

    repeat (40) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_addra", addra, 0);
    chk("async_rgb", {r, g, b}, 0);
    chk("async_de", de, 0);
    chk("async_fs", frame_start, 0);
    chk("async_hsync", hsync, 1);
    chk("async_vsync", vsync, 0);
    q.delete();

    push_frame(2, 4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(50, n);
    chk("post_reset_fs_latency", n, 5);
    enable = 1'b0;
    repeat (130) @(posedge clk);
    #1;
    chk("final_queue_drained", q.size(), 0);
    chk("final_de", de, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
